buffet_credit_producer: RTL and testbench
=========================================

# buffet_credit_producer

Credit-gated producer that drives the Fill (push) port of a buffet from an upstream stream. It tracks free buffet slots from the buffet's credit return port and forwards one upstream beat per available credit through a registered output stage. It therefore never pushes more data than the buffet has room for. It sits between a memory/DMA read stream and the buffet's push_data / credit interface.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each data beat
- IDX_WIDTH, 8, width of the credit return value (matches buffet index width)
- SIZE, 256, buffet capacity in entries; upper bound on held credits (must be ≤ 2^IDX_WIDTH)

Ports:
- clk  input  1  single clock, all logic rising-edge
- nreset_i  input  1  asynchronous, active-low reset
- src_data  input  DATA_WIDTH  upstream beat
- src_valid  input  1  upstream beat valid
- src_ready  output  1  beat accepted when src_valid & src_ready
- push_data  output  DATA_WIDTH  beat to buffet Fill port, registered
- push_data_valid  output  1  registered valid
- push_data_ready  input  1  buffet accepts beat when high with valid
- credit_in  input  IDX_WIDTH  number of slots freed by buffet
- credit_in_valid  input  1  credit_in valid
- credit_in_ready  output  1  credit accepted when valid & ready
- credit_count  output  IDX_WIDTH+1  current held credits, registered
- credit_overflow  output  1  sticky error, credits exceeded SIZE

## Operation
- Credit counter cnt, IDX_WIDTH+1 bits, reset 0; producer starts with no credits, buffet grants all slots via credit port.
- Credit accept: cred_fire = credit_in_valid & credit_in_ready; adds credit_in (zero-extended); credit_in = 0 accepted, no effect.
- Consume: src_fire = src_valid & src_ready; subtracts 1.
- Same-cycle update: cnt_next = cnt + (cred_fire ? credit_in : 0) − (src_fire ? 1 : 0), computed at IDX_WIDTH+2 bits.
- Output stage: one register (push_data, push_data_valid). stage_free = ~push_data_valid | push_data_ready.
- src_ready = (state == RUN) & (cnt != 0) & stage_free. Depends only on registered state and push_data_ready; never on src_valid.
- On src_fire, the register loads src_data and sets valid. On push_data_ready with no src_fire, valid clears. While valid & ~push_data_ready, push_data and valid hold stable.
- Credits arriving in cycle N are usable from cycle N+1 only; a consume never relies on the same-cycle credit.
- Two-state FSM:
  - RUN (reset state).
  - ERROR: entered when cnt_next > SIZE.
  - In ERROR: cnt saturates to SIZE, credit_overflow = 1, src_ready = 0, credit_in_ready = 0.
  - The already-loaded output beat still drains normally.
  - Exit only by reset.
- credit_in_ready = (state == RUN).
- Underflow is impossible by construction: a consume requires cnt ≥ 1.

## Timing
- Reset values:
  - push_data = 0, push_data_valid = 0
  - credit_count = 0, credit_overflow = 0
  - src_ready = 0 (cnt = 0), credit_in_ready = 1
- Asserting nreset_i low mid-stream clears everything immediately, asynchronously. An in-flight output beat and all held credits are discarded.
- Latency src_fire (edge N) → push_data_valid high after edge N.
- Credit accepted at edge N → src_ready may rise in cycle after edge N → first push_data_valid after edge N+1.
- Throughput: one beat per cycle while cnt ≥ 1 and push_data_ready = 1. There are no bubbles, including back-to-back credit grants.
- credit_count reflects all fires up to the previous edge.

## Test plan
- Reset, src_valid = 1, no credits for 10 cycles → src_ready = 0, push_data_valid = 0, credit_count = 0.
- credit_in = 4 for one cycle, then 6 beats 0xA0..0xA5 with push_data_ready = 1:
  - push_data shows 0xA0..0xA3 on 4 consecutive cycles.
  - credit_count goes 4→3→2→1→0.
  - src_ready then stays 0; 0xA4 is held upstream.
- cnt = 1, same cycle credit_in = 1 and src_fire → credit_count stays 1 next cycle; the next beat issues without a gap.
- cnt = 3, one beat in the output register, push_data_ready = 0 for 3 cycles:
  - push_data and valid stay stable.
  - src_ready = 0 and credit_count stays 2.
  - After ready returns, stream resumes at 1 beat/cycle.
- SIZE = 8: credit_in = 6 then credit_in = 3:
  - credit_overflow = 1 and credit_count = 8.
  - src_ready = 0 and credit_in_ready = 0 thereafter.
  - A new reset clears all of these.
- Reset pulsed while cnt = 5 and push_data_valid = 1 → outputs return to reset values the same cycle, and the post-reset stream needs new credits.

Source files
------------

// File: rtl/buffet_credit_producer.sv
// Purpose : credit-gated producer feeding a buffet Fill port from an upstream stream.
// Latency : one cycle from src_fire to push_data_valid; credits usable the cycle after acceptance.
// Backpressure: src_ready drops when no credits are held, the output stage is full and stalled, or after overflow.
//
// Ports:
//   clk, nreset_i                      - clock, asynchronous active-low reset
//   src_data/src_valid/src_ready       - upstream beat handshake
//   push_data/push_data_valid/_ready   - registered beat to the buffet Fill port
//   credit_in/credit_in_valid/_ready   - slots freed by the buffet
//   credit_count                       - credits currently held (registered)
//   credit_overflow                    - sticky: buffet returned more credits than SIZE
module buffet_credit_producer #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 8,
    parameter int SIZE       = 256
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_data_valid,
    input  logic                  push_data_ready,
    input  logic [IDX_WIDTH-1:0]  credit_in,
    input  logic                  credit_in_valid,
    output logic                  credit_in_ready,
    output logic [IDX_WIDTH:0]    credit_count,
    output logic                  credit_overflow
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_ERROR = 1'b1;

    // Sum is two bits wider than the index so cnt + credit_in never wraps.
    localparam int                 CW       = IDX_WIDTH + 2;
    localparam logic [CW-1:0]      SIZE_SUM = CW'(SIZE);
    localparam logic [IDX_WIDTH:0] SIZE_CNT = (IDX_WIDTH + 1)'(SIZE);

    logic [0:0]            state_q, state_d;
    logic [IDX_WIDTH:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;

    logic                  stage_free;
    logic                  cred_fire;
    logic                  src_fire;
    logic [CW-1:0]         cnt_sum;

    // src_ready uses only registered state plus push_data_ready, so a consume
    // can never lean on a credit arriving in the same cycle.
    assign stage_free      = ~vld_q | push_data_ready;
    assign src_ready       = (state_q == ST_RUN) & (cnt_q != '0) & stage_free;
    assign credit_in_ready = (state_q == ST_RUN);

    assign cred_fire = credit_in_valid & credit_in_ready;
    assign src_fire  = src_valid & src_ready;

    // No underflow: src_fire implies cnt_q >= 1.
    assign cnt_sum = {1'b0, cnt_q}
                   + (cred_fire ? {2'b00, credit_in} : {CW{1'b0}})
                   - {{(CW-1){1'b0}}, src_fire};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_RUN) begin
            if (cnt_sum > SIZE_SUM) begin
                state_d = ST_ERROR;
                cnt_d   = SIZE_CNT;
            end else begin
                cnt_d = cnt_sum[IDX_WIDTH:0];
            end
        end else begin
            cnt_d = SIZE_CNT;
        end
    end

    // Output stage: load on fire, clear when drained, hold while stalled.
    // Overflow does not touch this stage, so a loaded beat still drains.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (src_fire) begin
            data_d = src_data;
            vld_d  = 1'b1;
        end else if (push_data_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign push_data       = data_q;
    assign push_data_valid = vld_q;
    assign credit_count    = cnt_q;
    assign credit_overflow = (state_q == ST_ERROR);

endmodule

// File: tb/tb_buffet_credit_producer.sv
module tb_buffet_credit_producer;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SZ = 8;

    logic          clk = 1'b0;
    logic          nreset_i;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] push_data;
    logic          push_data_valid;
    logic          push_data_ready;
    logic [IW-1:0] credit_in;
    logic          credit_in_valid;
    logic          credit_in_ready;
    logic [IW:0]   credit_count;
    logic          credit_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: integer credit pool, sticky error flag, one-deep output slot.
    int            m_cnt;
    bit            m_err;
    bit            m_vld;
    logic [DW-1:0] m_data;
    logic [DW-1:0] srcq[$];
    bit            last_sf;

    buffet_credit_producer #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .SIZE(SZ)) dut (
        .clk             (clk),
        .nreset_i        (nreset_i),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .push_data       (push_data),
        .push_data_valid (push_data_valid),
        .push_data_ready (push_data_ready),
        .credit_in       (credit_in),
        .credit_in_valid (credit_in_valid),
        .credit_in_ready (credit_in_ready),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_err  = 1'b0;
        m_vld  = 1'b0;
        m_data = '0;
    endtask

    function automatic bit m_src_ready();
        return !m_err && (m_cnt > 0) && (!m_vld || push_data_ready);
    endfunction

    task automatic check_regs();
        chk("push_data_valid", 64'(push_data_valid), 64'(m_vld));
        chk("push_data",       64'(push_data),       64'(m_data));
        chk("credit_count",    64'(credit_count),    64'(m_cnt));
        chk("credit_overflow", 64'(credit_overflow), 64'(m_err));
    endtask

    // One clock: check handshake outputs mid-cycle, advance model at the edge,
    // check registered outputs just after it.
    task automatic step();
        bit cf;
        bit sf;
        int nxt;
        @(negedge clk);
        chk("src_ready",       64'(src_ready),       64'(m_src_ready()));
        chk("credit_in_ready", 64'(credit_in_ready), 64'(!m_err));
        cf = credit_in_valid && !m_err;
        sf = src_valid && m_src_ready();
        @(posedge clk);
        nxt = m_cnt + (cf ? int'(credit_in) : 0) - (sf ? 1 : 0);
        if (!m_err) begin
            if (nxt > SZ) begin
                m_err = 1'b1;
                m_cnt = SZ;
            end else begin
                m_cnt = nxt;
            end
        end
        if (sf) begin
            m_vld  = 1'b1;
            m_data = src_data;
        end else if (push_data_ready) begin
            m_vld = 1'b0;
        end
        last_sf = sf;
        #1;
        check_regs();
    endtask

    // Step while presenting the head of srcq upstream.
    task automatic q_step();
        src_valid = (srcq.size() > 0);
        src_data  = (srcq.size() > 0) ? srcq[0] : '0;
        step();
        if (last_sf) void'(srcq.pop_front());
    endtask

    initial begin
        nreset_i        = 1'b0;
        src_valid       = 1'b1;
        src_data        = 32'hDEAD_BEEF;
        push_data_ready = 1'b1;
        credit_in       = '0;
        credit_in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_push_valid",   64'(push_data_valid), 64'(1'b0));
        chk("rst_push_data",    64'(push_data),       64'(0));
        chk("rst_credit_count", 64'(credit_count),    64'(0));
        chk("rst_overflow",     64'(credit_overflow), 64'(1'b0));
        chk("rst_src_ready",    64'(src_ready),       64'(1'b0));
        chk("rst_credit_rdy",   64'(credit_in_ready), 64'(1'b1));
        nreset_i = 1'b1;

        // No credits: nothing may move despite src_valid.
        repeat (10) step();
        chk("nocred_src_ready", 64'(src_ready),       64'(1'b0));
        chk("nocred_valid",     64'(push_data_valid), 64'(1'b0));
        chk("nocred_count",     64'(credit_count),    64'(0));

        // Grant 4, offer 6 beats: exactly 4 go out back-to-back.
        for (int i = 0; i < 6; i++) srcq.push_back(32'(32'hA0 + i));
        credit_in = 4'd4;
        credit_in_valid = 1'b1;
        q_step();
        credit_in_valid = 1'b0;
        chk("grant4_count", 64'(credit_count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            q_step();
            chk("grant4_data",  64'(push_data),       64'(32'hA0 + i));
            chk("grant4_valid", 64'(push_data_valid), 64'(1'b1));
            chk("grant4_cnt",   64'(credit_count),    64'(3 - i));
        end
        repeat (3) begin
            q_step();
            chk("starved_src_ready", 64'(src_ready),       64'(1'b0));
            chk("starved_valid",     64'(push_data_valid), 64'(1'b0));
        end

        // cnt=1 with simultaneous credit and consume: count holds, no gap.
        credit_in = 4'd1;
        credit_in_valid = 1'b1;
        q_step();
        chk("same_pre_cnt", 64'(credit_count), 64'(1));
        q_step();
        chk("same_cnt",  64'(credit_count), 64'(1));
        chk("same_data", 64'(push_data),    64'(32'hA4));
        credit_in_valid = 1'b0;
        q_step();
        chk("same_next_data",  64'(push_data),       64'(32'hA5));
        chk("same_next_valid", 64'(push_data_valid), 64'(1'b1));
        chk("same_next_cnt",   64'(credit_count),    64'(0));
        q_step();

        // Stall with a beat held in the output register.
        for (int i = 0; i < 6; i++) srcq.push_back(32'(32'hB0 + i));
        credit_in = 4'd3;
        credit_in_valid = 1'b1;
        q_step();
        credit_in_valid = 1'b0;
        q_step();
        chk("stall_pre_data", 64'(push_data), 64'(32'hB0));
        push_data_ready = 1'b0;
        repeat (3) begin
            q_step();
            chk("stall_data",      64'(push_data),       64'(32'hB0));
            chk("stall_valid",     64'(push_data_valid), 64'(1'b1));
            chk("stall_src_ready", 64'(src_ready),       64'(1'b0));
            chk("stall_cnt",       64'(credit_count),    64'(2));
        end
        push_data_ready = 1'b1;
        q_step();
        chk("resume_data1", 64'(push_data),    64'(32'hB1));
        chk("resume_cnt1",  64'(credit_count), 64'(1));
        q_step();
        chk("resume_data2", 64'(push_data),    64'(32'hB2));
        chk("resume_cnt2",  64'(credit_count), 64'(0));
        srcq.delete();
        q_step();

        // Overflow: 6 + 3 > 8.
        credit_in = 4'd6;
        credit_in_valid = 1'b1;
        q_step();
        credit_in = 4'd3;
        q_step();
        chk("ovf_flag", 64'(credit_overflow), 64'(1'b1));
        chk("ovf_cnt",  64'(credit_count),    64'(SZ));
        credit_in = 4'd1;
        src_valid = 1'b1;
        repeat (3) begin
            step();
            chk("ovf_src_ready",  64'(src_ready),       64'(1'b0));
            chk("ovf_credit_rdy", 64'(credit_in_ready), 64'(1'b0));
        end
        credit_in_valid = 1'b0;
        nreset_i = 1'b0;
        #1;
        model_reset();
        chk("ovf_rst_flag", 64'(credit_overflow), 64'(1'b0));
        chk("ovf_rst_cnt",  64'(credit_count),    64'(0));
        chk("ovf_rst_crdy", 64'(credit_in_ready), 64'(1'b1));
        nreset_i = 1'b1;

        // Async reset with credits held and a beat in flight.
        for (int i = 0; i < 4; i++) srcq.push_back(32'(32'hC0 + i));
        credit_in = 4'd6;
        credit_in_valid = 1'b1;
        q_step();
        credit_in_valid = 1'b0;
        push_data_ready = 1'b0;
        q_step();
        chk("midrst_pre_cnt",   64'(credit_count),    64'(5));
        chk("midrst_pre_valid", 64'(push_data_valid), 64'(1'b1));
        #1 nreset_i = 1'b0;
        #1;
        chk("midrst_valid", 64'(push_data_valid), 64'(1'b0));
        chk("midrst_data",  64'(push_data),       64'(0));
        chk("midrst_cnt",   64'(credit_count),    64'(0));
        model_reset();
        #1 nreset_i = 1'b1;
        push_data_ready = 1'b1;
        repeat (3) begin
            q_step();
            chk("postrst_src_ready", 64'(src_ready),       64'(1'b0));
            chk("postrst_valid",     64'(push_data_valid), 64'(1'b0));
        end
        credit_in = 4'd2;
        credit_in_valid = 1'b1;
        q_step();
        credit_in_valid = 1'b0;
        q_step();
        chk("postrst_data", 64'(push_data), 64'(32'hC1));
        srcq.delete();

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                nreset_i = 1'b0;
                #1;
                model_reset();
                chk("rand_rst_cnt", 64'(credit_count), 64'(0));
                nreset_i = 1'b1;
            end
            src_valid       = 1'($urandom_range(0, 1));
            src_data        = $urandom;
            push_data_ready = ($urandom_range(0, 3) != 0);
            credit_in_valid = ($urandom_range(0, 2) == 0);
            credit_in       = 4'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
